// File: rtl/shift_reg_pkg.sv
// Shared types and sizing helpers for the serial-in deserializer front end.
package shift_reg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } ctrl_state_t;

    localparam int unsigned DEFAULT_WIDTH        = 3;
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 1;

    // Bits needed to hold every value 0..max_val (at least one bit).
    function automatic int unsigned count_w(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/shift_reg_en.sv
// Serial-in / parallel-out register: ser_in enters the MSB, contents move toward the LSB.
module shift_reg_en
    import shift_reg_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             shift_en,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (shift_en) begin
            data_d = {ser_in, data_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/shift_reg_ctrl.sv
// Deserializer controller: paces WIDTH serial bits into shift_reg_en, then
// presents the word with a valid/ready handshake and a sticky overrun flag.
module shift_reg_ctrl
    import shift_reg_pkg::*;
#(
    parameter int unsigned WIDTH        = DEFAULT_WIDTH,
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                      clk,
    input  logic                      Reset,
    input  logic                      start,
    input  logic                      ser_in,
    input  logic                      word_ready,
    output logic                      shift_en,
    output logic                      busy,
    output logic                      word_valid,
    output logic [WIDTH-1:0]          word_out,
    output logic [count_w(WIDTH)-1:0] bit_cnt,
    output logic                      overrun
);

    localparam int unsigned      CNT_W    = count_w(WIDTH);
    localparam int unsigned      DIV_W    = count_w(CLKS_PER_BIT - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    ctrl_state_t      state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             ovr_q, ovr_d;
    logic [WIDTH-1:0] sr_q;

    shift_reg_en #(
        .WIDTH(WIDTH)
    ) u_sr (
        .clk      (clk),
        .Reset    (Reset),
        .shift_en (shift_en),
        .ser_in   (ser_in),
        .q        (sr_q)
    );

    assign shift_en = (state_q == SHIFT) && (div_q == DIV_LAST);

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        ovr_d   = ovr_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    div_d   = '0;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                if (shift_en) begin
                    div_d = '0;
                    cnt_d = cnt_q + 1'b1;
                    // Capture the post-shift value the datapath will hold after this edge.
                    if (cnt_q == CNT_LAST) begin
                        word_d  = {ser_in, sr_q[WIDTH-1:1]};
                        state_d = HOLD;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            HOLD: begin
                if (word_ready) begin
                    if (start) begin
                        state_d = SHIFT;
                        div_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (start) begin
                    ovr_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            ovr_q   <= ovr_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign word_valid = (state_q == HOLD);
    assign word_out   = word_q;
    assign bit_cnt    = cnt_q;
    assign overrun    = ovr_q;

endmodule

// File: doc/shift_reg_ctrl.md
Name: shift_reg_ctrl

Overview:
- Sequencing controller for the serial-in shift register datapath; builds a deserializer front end.
- Accepts a start request, then paces WIDTH serial bits into the shift register, one bit every CLKS_PER_BIT clocks.
- Presents the assembled word with a valid/ready handshake, flags lost start requests, and then returns idle.
- Sits between a serial source and any parallel consumer.

Parameters:
- WIDTH, 3: bits per word and shift-register length; legal range ≥2.
- CLKS_PER_BIT, 1: clocks per bit period; legal range ≥1.

Ports:
- clk, input, 1: single system clock; all logic is on the rising edge.
- Reset, input, 1: synchronous, active-high reset; it has priority over every other input.
- start, input, 1: frame request; it is sampled only in IDLE, or in HOLD together with word_ready.
- ser_in, input, 1: serial data; it is sampled on cycles where shift_en=1.
- word_ready, input, 1: the consumer accepts word_out.
- shift_en, output, 1: single-cycle shift strobe to the datapath.
- busy, output, 1: high in SHIFT and HOLD.
- word_valid, output, 1: high in HOLD.
- word_out, output, WIDTH: assembled word.
- bit_cnt, output, clog2(WIDTH+1): number of bits shifted in the current frame.
- overrun, output, 1: sticky flag for a lost start request.

Behaviour:
- Reset values, applied at any clk edge with Reset=1, mid-frame included:
  - state=IDLE.
  - Divider=0, bit_cnt=0, shift register=0, word_out=0.
  - shift_en=0, busy=0, word_valid=0, overrun=0.
- FSM states: IDLE, SHIFT, HOLD.
- IDLE:
  - start=1 → SHIFT; divider and bit_cnt cleared.
  - Otherwise stay in IDLE.
- SHIFT:
  - The divider counts 0..CLKS_PER_BIT-1 and wraps to 0.
  - shift_en is combinational: shift_en = (state==SHIFT) && (div==CLKS_PER_BIT-1).
  - On an edge with shift_en=1:
    - ser_in enters the MSB.
    - Every bit moves one position toward the LSB; the old LSB is dropped.
    - bit_cnt increments.
  - On the edge where bit_cnt reaches WIDTH:
    - word_out is loaded with the post-shift register value.
    - State → HOLD.
  - start is ignored in SHIFT.
- Bit order: the first received bit lands in word_out[0]; the last received bit lands in word_out[WIDTH-1].
- Latency, counting the edge that accepts start as edge 0:
  - Shifts occur at edges k·CLKS_PER_BIT for k=1..WIDTH.
  - word_valid rises after edge WIDTH·CLKS_PER_BIT.
- HOLD:
  - word_valid=1; word_out is stable.
  - word_ready=1 and start=0 → IDLE at that edge.
  - word_ready=1 and start=1 → SHIFT directly at that edge, with divider and bit_cnt cleared. This gives back-to-back frames with no idle cycle.
  - start=1 with word_ready=0: the request is dropped and overrun is set at that edge.
- overrun is cleared only by Reset.
- word_out keeps its value after the handshake until the next frame completes.
- bit_cnt resets to 0 on entering SHIFT, and holds WIDTH during HOLD.
- shift_en is never high outside SHIFT, and is high on exactly WIDTH cycles per frame.

Decomposition:
- Package shift_reg_pkg holds:
  - State enum ctrl_state_t (IDLE, SHIFT, HOLD).
  - Default WIDTH and CLKS_PER_BIT constants.
  - clog2-based width helpers.
- Sub-module shift_reg_en:
  - Parameterised WIDTH serial-in/parallel-out register with a shift enable and synchronous active-high Reset.
  - It is the datapath this controller drives.
- The controller top holds the FSM, the divider, bit_cnt, the word_out capture register and overrun.

Test Plan:
- Reset check: WIDTH=3, CLKS_PER_BIT=1; Reset high for 2 edges → word_out=000, word_valid=0, busy=0, overrun=0, bit_cnt=0.
- Single frame: start at edge 0; ser_in=1,1,0 at edges 1,2,3; word_ready=0 → shift_en high for cycles 1–3; word_valid=1 after edge 3; word_out=3'b011. Then word_ready=1 → IDLE next edge and word_out still 011.
- Pacing: CLKS_PER_BIT=4, WIDTH=3 → shift_en high at cycles 4, 8, 12 only; word_valid after edge 12; bit_cnt steps 0→1→2→3.
- Back-to-back: in HOLD, start=1 and word_ready=1 on the same edge → next cycle state=SHIFT, busy stays 1, word_valid=0, no idle gap. The second word, 3'b101, is captured correctly.
- Overrun: in HOLD, start=1 with word_ready=0 → overrun=1, state stays HOLD, word_out unchanged. overrun stays 1 after the handshake until Reset.
- Mid-frame reset: Reset=1 after the second shift → next cycle all outputs at reset values. A start 2 cycles later runs a clean full frame with bit_cnt counting from 0.
